// File: rtl/trojan_leak_lfsr_gen_pkg.sv
// ----------------------------------------------------------------------------
// trojan_pkg
// Shared definitions for the trojan_leak_lfsr_gen benchmark block:
//   - state_e    : leak controller state (IDLE / ARMED / LEAK), 2-bit encoded
//   - lfsr_next  : one Fibonacci shift-left step for an LFSR of up to 32 bits
// ----------------------------------------------------------------------------
package trojan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LEAK  = 2'd2
    } state_e;

    // Fibonacci step: the parity of the tapped bits enters at bit 0 while the
    // register shifts left. Bits at or above 'width' are forced to zero so one
    // function serves every LFSR width up to 32.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] value,
        input logic [31:0] taps,
        input int unsigned width
    );
        logic [31:0] wmask;
        logic        fb;
        wmask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb    = ^(value & taps & wmask);
        return ((value << 1) | {31'd0, fb}) & wmask;
    endfunction

endpackage

// File: rtl/trojan_leak_lfsr_gen_lfsr.sv
// ----------------------------------------------------------------------------
// trojan_lfsr
// Free-running Fibonacci LFSR that produces the key mask. It advances on every
// clock edge and reloads its seed whenever it is found at zero (lock-up
// escape). The mask is the current register value replicated REP times.
//
// Ports:
//   clk    in   single clock, posedge
//   rst_n  in   synchronous active-low reset (loads LFSR_SEED)
//   mask   out  {REP{lfsr}}, the pre-advance LFSR value replicated
// ----------------------------------------------------------------------------
module trojan_lfsr
    import trojan_pkg::*;
#(
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hDEAD,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter int unsigned       REP       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [LFSR_W*REP-1:0]   mask
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [31:0]       step;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        step   = lfsr_next(32'(lfsr_q), 32'(LFSR_TAPS), LFSR_W);
        lfsr_d = step[LFSR_W-1:0];
        if (lfsr_q == '0) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign mask = {REP{lfsr_q}};

endmodule

// File: rtl/trojan_leak_lfsr_gen.sv
// ----------------------------------------------------------------------------
// trojan_leak_lfsr_gen
// Trigger-armed key leak benchmark. In IDLE it counts consecutive matches of
// TRIG_PATTERN on the side-band bus (valid-qualified; a mismatch restarts the
// count, an invalid cycle holds it). After TRIG_HITS matches it spends one
// ARMED cycle snapshotting the key and loading the burst length, then LEAKs
// key_snap ^ mask for LEAK_LEN cycles and returns to IDLE.
//
// Ports:
//   clk         in   single clock, posedge
//   rst_n       in   synchronous active-low reset
//   trig_valid  in   qualifies trig_data
//   trig_data   in   [TRIG_W] side-band trigger bus
//   key         in   [KEY_W]  secret key
//   leak        out  [KEY_W]  masked key during the burst, else 0 (registered)
//   leak_valid  out  high exactly during burst cycles (registered)
//   active      out  high whenever the state is not IDLE
// ----------------------------------------------------------------------------
module trojan_leak_lfsr_gen
    import trojan_pkg::*;
#(
    parameter int unsigned       KEY_W        = 64,
    parameter int unsigned       LFSR_W       = 16,
    parameter logic [31:0]       LFSR_SEED    = 32'h0000_DEAD,
    parameter logic [31:0]       LFSR_TAPS    = 32'h0000_B400,
    parameter int unsigned       TRIG_W       = 8,
    parameter logic [TRIG_W-1:0] TRIG_PATTERN = 8'hA5,
    parameter int unsigned       TRIG_HITS    = 3,
    parameter int unsigned       LEAK_LEN     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_valid,
    input  logic [TRIG_W-1:0] trig_data,
    input  logic [KEY_W-1:0]  key,
    output logic [KEY_W-1:0]  leak,
    output logic              leak_valid,
    output logic              active
);

    localparam int unsigned REP      = KEY_W / LFSR_W;
    localparam logic [7:0]  HITS     = 8'(TRIG_HITS);
    localparam logic [15:0] LEN_INIT = 16'(LEAK_LEN - 1);

    logic [KEY_W-1:0] mask;

    trojan_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_SEED (LFSR_SEED[LFSR_W-1:0]),
        .LFSR_TAPS (LFSR_TAPS[LFSR_W-1:0]),
        .REP       (REP)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .mask  (mask)
    );

    state_e           state_q,      state_d;
    logic [7:0]       hit_cnt_q,    hit_cnt_d;
    logic [15:0]      len_cnt_q,    len_cnt_d;
    logic [KEY_W-1:0] key_snap_q,   key_snap_d;
    logic [KEY_W-1:0] leak_q,       leak_d;
    logic             leak_valid_q, leak_valid_d;
    logic [7:0]       hit_inc;

    assign hit_inc = hit_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        hit_cnt_d    = hit_cnt_q;
        len_cnt_d    = len_cnt_q;
        key_snap_d   = key_snap_q;
        leak_d       = '0;
        leak_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig_valid) begin
                    if (trig_data == TRIG_PATTERN) begin
                        if (hit_inc == HITS) begin
                            state_d   = ARMED;
                            hit_cnt_d = '0;
                        end else begin
                            hit_cnt_d = hit_inc;
                        end
                    end else begin
                        hit_cnt_d = '0;
                    end
                end
            end

            ARMED: begin
                key_snap_d = key;
                len_cnt_d  = LEN_INIT;
                state_d    = LEAK;
            end

            LEAK: begin
                // Triggers are ignored here, including on the exit cycle.
                leak_d       = key_snap_q ^ mask;
                leak_valid_d = 1'b1;
                hit_cnt_d    = '0;
                if (len_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    len_cnt_d = len_cnt_q - 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hit_cnt_q    <= '0;
            len_cnt_q    <= '0;
            // NOTE: key_snap holds secret data, so it is explicitly cleared on reset rather than left stale.
            key_snap_q   <= '0;
            leak_q       <= '0;
            leak_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_cnt_q    <= hit_cnt_d;
            len_cnt_q    <= len_cnt_d;
            key_snap_q   <= key_snap_d;
            leak_q       <= leak_d;
            leak_valid_q <= leak_valid_d;
        end
    end

    assign leak       = leak_q;
    assign leak_valid = leak_valid_q;
    assign active     = (state_q != IDLE);

endmodule

// File: tb/tb_trojan_leak_lfsr_gen.sv
// ----------------------------------------------------------------------------
// tb_trojan_leak_lfsr_gen
// Two instances: u_dut with default parameters and u_var with the small
// variant (KEY_W=32, LFSR_W=8, seed 01, taps B8, TRIG_HITS=1, LEAK_LEN=1).
// A behavioural model predicts each instance's outputs from the timing rules:
// a firing match at edge E makes active high for edges E..E+LEN, leak_valid
// high for edges E+2..E+1+LEN, the key is captured at edge E+1, and matches
// are ignored up to and including edge E+1+LEN.
// ----------------------------------------------------------------------------
module tb_trojan_leak_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tv0, tv1;
    logic [7:0]  td0, td1;
    logic [63:0] key0;
    logic [31:0] key1;
    logic [63:0] leak0;
    logic [31:0] leak1;
    logic        lv0, lv1, act0, act1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    trojan_leak_lfsr_gen u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_valid (tv0),
        .trig_data  (td0),
        .key        (key0),
        .leak       (leak0),
        .leak_valid (lv0),
        .active     (act0)
    );

    trojan_leak_lfsr_gen #(
        .KEY_W     (32),
        .LFSR_W    (8),
        .LFSR_SEED (32'h01),
        .LFSR_TAPS (32'hB8),
        .TRIG_HITS (1),
        .LEAK_LEN  (1)
    ) u_var (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_valid (tv1),
        .trig_data  (td1),
        .key        (key1),
        .leak       (leak1),
        .leak_valid (lv1),
        .active     (act1)
    );

    // ---------------------------------------------------------------- model
    typedef struct {
        int          kw;
        int          lw;
        logic [31:0] seed;
        logic [31:0] taps;
        int          need;
        int          len;
        logic [7:0]  pat;
        logic [31:0] lfsr;
        int          hits;
        bit          fired;
        int          e;
        logic [63:0] snap;
        logic        exp_valid;
        logic        exp_active;
        logic [63:0] exp_leak;
    } model_t;

    model_t m[2];

    // Arithmetic LFSR step: double modulo 2^w plus the parity of tapped ones.
    function automatic logic [31:0] m_step(logic [31:0] v, logic [31:0] taps,
                                           int w, logic [31:0] seed);
        longint unsigned val  = 64'(v);
        longint unsigned modv = 64'd1 << w;
        int              ones = 0;
        if (v == 32'd0) return seed;
        for (int b = 0; b < w; b++) begin
            if (taps[b] && v[b]) ones++;
        end
        return 32'((val * 2) % modv + longint'(ones % 2));
    endfunction

    function automatic logic [63:0] m_rep(logic [31:0] v, int lw, int kw);
        logic [63:0] r = '0;
        for (int j = 0; j < kw / lw; j++) begin
            r = r | (64'(v) << (j * lw));
        end
        return r;
    endfunction

    task automatic model_edge(int i, logic r, logic v, logic [7:0] d, logic [63:0] k);
        logic [31:0] pre;
        bit          in_win;
        if (!r) begin
            m[i].lfsr       = m[i].seed;
            m[i].hits       = 0;
            m[i].fired      = 0;
            m[i].exp_valid  = 1'b0;
            m[i].exp_active = 1'b0;
            m[i].exp_leak   = '0;
        end else begin
            pre         = m[i].lfsr;
            m[i].lfsr   = m_step(m[i].lfsr, m[i].taps, m[i].lw, m[i].seed);
            in_win      = m[i].fired && (cyc <= m[i].e + 1 + m[i].len);
            if (m[i].fired && cyc == m[i].e + 1) m[i].snap = k;
            m[i].exp_valid  = m[i].fired && cyc >= m[i].e + 2 && cyc <= m[i].e + 1 + m[i].len;
            m[i].exp_active = m[i].fired && cyc >= m[i].e && cyc <= m[i].e + m[i].len;
            m[i].exp_leak   = m[i].exp_valid ? (m[i].snap ^ m_rep(pre, m[i].lw, m[i].kw)) : 64'd0;
            if (!in_win && v) begin
                if (d == m[i].pat) begin
                    m[i].hits++;
                    if (m[i].hits == m[i].need) begin
                        m[i].fired      = 1;
                        m[i].e          = cyc;
                        m[i].hits       = 0;
                        m[i].exp_active = 1'b1;
                    end
                end else begin
                    m[i].hits = 0;
                end
            end
        end
    endtask

    // --------------------------------------------------------------- checks
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle(logic r, logic v0, logic [7:0] d0, logic [63:0] k0,
                         logic v1, logic [7:0] d1, logic [31:0] k1);
        rst_n = r;
        tv0   = v0;
        td0   = d0;
        key0  = k0;
        tv1   = v1;
        td1   = d1;
        key1  = k1;
        @(posedge clk);
        cyc++;
        model_edge(0, r, v0, d0, k0);
        model_edge(1, r, v1, d1, {32'd0, k1});
        @(negedge clk);
        check("leak0",  leak0,          m[0].exp_leak);
        check("valid0", 64'(lv0),       64'(m[0].exp_valid));
        check("active0",64'(act0),      64'(m[0].exp_active));
        check("leak1",  {32'd0, leak1}, m[1].exp_leak);
        check("valid1", 64'(lv1),       64'(m[1].exp_valid));
        check("active1",64'(act1),      64'(m[1].exp_active));
    endtask

    // Drive only the default instance; the variant stays idle.
    task automatic c0(logic v, logic [7:0] d, logic [63:0] k);
        cycle(1'b1, v, d, k, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic idle0(int n, logic [63:0] k);
        for (int j = 0; j < n; j++) c0(1'b0, 8'h00, k);
    endtask

    localparam logic [63:0] KEY_A = 64'h0123_4567_89AB_CDEF;

    initial begin
        int cnt;
        m[0] = '{kw:64, lw:16, seed:32'hDEAD, taps:32'hB400, need:3, len:32, pat:8'hA5,
                 lfsr:32'hDEAD, hits:0, fired:0, e:0, snap:'0,
                 exp_valid:1'b0, exp_active:1'b0, exp_leak:'0};
        m[1] = '{kw:32, lw:8, seed:32'h01, taps:32'hB8, need:1, len:1, pat:8'hA5,
                 lfsr:32'h01, hits:0, fired:0, e:0, snap:'0,
                 exp_valid:1'b0, exp_active:1'b0, exp_leak:'0};

        // Reset held for three edges, then the LFSR starts DEAD -> BD5B.
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 32'h0);
        check("rst_leak0",  leak0, 64'h0);
        check("rst_valid0", 64'(lv0), 64'h0);
        check("lfsr_seed",  64'(u_dut.u_lfsr.lfsr_q), 64'hDEAD);
        c0(1'b0, 8'h00, 64'h0);
        check("lfsr_step1", 64'(u_dut.u_lfsr.lfsr_q), 64'hBD5B);

        // Forced burst with key = 0: leak is the bare replicated LFSR.
        for (int j = 0; j < 3; j++) c0(1'b1, 8'hA5, 64'h0);
        idle0(36, 64'h0);

        // A5, A5, gap, A5 fires; first leak_valid two cycles after the match.
        c0(1'b1, 8'hA5, 64'h0);
        c0(1'b1, 8'hA5, 64'h0);
        c0(1'b0, 8'hA5, 64'h0);
        c0(1'b1, 8'hA5, 64'h0);
        check("gap_active", 64'(act0), 64'h1);
        c0(1'b0, 8'h00, 64'h0);
        check("gap_valid_e1", 64'(lv0), 64'h0);
        c0(1'b0, 8'h00, 64'h0);
        check("gap_valid_e2", 64'(lv0), 64'h1);
        idle0(34, 64'h0);

        // A5, A5, 3C, A5 does not fire; a mismatch then clears the stray hit.
        c0(1'b1, 8'hA5, 64'h0);
        c0(1'b1, 8'hA5, 64'h0);
        c0(1'b1, 8'h3C, 64'h0);
        c0(1'b1, 8'hA5, 64'h0);
        idle0(4, 64'h0);
        check("nofire_active", 64'(act0), 64'h0);
        c0(1'b1, 8'h00, 64'h0);

        // Burst content: key captured on the ARMED cycle, then changed to 0.
        for (int j = 0; j < 3; j++) c0(1'b1, 8'hA5, KEY_A);
        c0(1'b0, 8'h00, KEY_A);
        cnt = 0;
        for (int j = 0; j < 36; j++) begin
            c0(1'b0, 8'h00, 64'h0);
            if (lv0) cnt++;
        end
        check("burst_len", 64'(cnt), 64'd32);

        // Reset asserted on burst cycle 10 aborts the burst.
        for (int j = 0; j < 3; j++) c0(1'b1, 8'hA5, KEY_A);
        idle0(10, KEY_A);
        cycle(1'b0, 1'b0, 8'h00, KEY_A, 1'b0, 8'h00, 32'h0);
        check("abort_leak",   leak0, 64'h0);
        check("abort_valid",  64'(lv0), 64'h0);
        check("abort_active", 64'(act0), 64'h0);
        c0(1'b1, 8'hA5, KEY_A);
        c0(1'b1, 8'hA5, KEY_A);
        idle0(3, KEY_A);
        check("rearm_two_hits", 64'(act0), 64'h0);
        c0(1'b1, 8'hA5, KEY_A);
        check("rearm_third_hit", 64'(act0), 64'h1);
        idle0(36, KEY_A);

        // Matches during LEAK and on the exit cycle are ignored.
        for (int j = 0; j < 3; j++) c0(1'b1, 8'hA5, KEY_A);
        for (int j = 0; j < 33; j++) c0(1'b1, 8'hA5, KEY_A);
        check("exit_hit_cnt", 64'(u_dut.hit_cnt_q), 64'h0);
        check("exit_active",  64'(act0), 64'h0);
        idle0(3, KEY_A);

        // Variant: a single match gives exactly one leak_valid cycle.
        cycle(1'b1, 1'b0, 8'h00, 64'h0, 1'b1, 8'hA5, 32'hCAFE_F00D);
        cnt = 0;
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 32'h0);
            if (lv1) cnt++;
        end
        check("var_burst_len", 64'(cnt), 64'd1);

        // Variant LFSR period, bounded so a broken LFSR cannot hang the run.
        cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 32'h0);
        cnt = 0;
        for (int j = 1; j <= 600; j++) begin
            cycle(1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 8'h00, 32'h0);
            if (u_var.u_lfsr.lfsr_q == 8'h01) begin
                cnt = j;
                break;
            end
        end
        check("var_period", 64'(cnt), 64'd255);

        // Randomized traffic on both instances, biased toward the pattern.
        for (int j = 0; j < 4000; j++) begin
            logic        r, v0, v1;
            logic [7:0]  d0, d1;
            r  = ($urandom_range(0, 499) != 0);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 7) == 0);
            d0 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hA5;
            d1 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hA5;
            if ($urandom_range(0, 7) == 0) key0 = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) key1 = $urandom;
            cycle(r, v0, d0, key0, v1, d1, key1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trojan_leak_lfsr_gen.md
# trojan_leak_lfsr_gen

Parametrised successor to the always-on key-masking leak benchmark. It stays silent until a trigger pattern is seen on a side-band input for a set number of matches. It then snapshots the key and emits it XOR-masked with a configurable LFSR stream for a bounded burst, and re-arms. It is a detection-benchmark circuit for the Trojan RTL set, and a standalone leaf instance.

## Interface
- KEY_W, 64, key/leak width; must be an integer multiple of LFSR_W
- LFSR_W, 16, LFSR width (4..32)
- LFSR_SEED, 16'hDEAD (zero-extended/truncated to LFSR_W), reset and reload value; must be nonzero
- LFSR_TAPS, 16'hB400, feedback tap mask; bit i set means lfsr[i] feeds back
- TRIG_W, 8, trigger data width
- TRIG_PATTERN, 8'hA5, trigger match value
- TRIG_HITS, 3, matches needed to fire (1..255)
- LEAK_LEN, 32, burst length in cycles (1..65535)
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- trig_valid  in  1  qualifies trig_data
- trig_data  in  TRIG_W  side-band trigger bus
- key  in  KEY_W  secret key
- leak  out  KEY_W  masked key during burst, else 0
- leak_valid  out  1  high exactly during burst cycles
- active  out  1  high whenever the state is not IDLE

## Operation
- LFSR: Fibonacci, shift left. The feedback bit is ^(lfsr & LFSR_TAPS) and enters at bit 0. It advances every cycle regardless of state. If its value is ever 0, it reloads LFSR_SEED on the next edge.
- mask = {KEY_W/LFSR_W{lfsr}}, using the current (pre-advance) LFSR value.
- States are IDLE, ARMED and LEAK, and the state is encoded in 2 bits.
- IDLE:
  - A cycle with trig_valid=1 and trig_data==TRIG_PATTERN increments hit_cnt.
  - A cycle with trig_valid=1 and a mismatch clears hit_cnt.
  - A cycle with trig_valid=0 holds hit_cnt.
  - When a match brings hit_cnt to TRIG_HITS, go to ARMED and clear hit_cnt.
- ARMED:
  - Lasts one cycle.
  - key_snap <= key.
  - len_cnt <= LEAK_LEN-1.
  - Go to LEAK.
- LEAK:
  - leak <= key_snap ^ mask and leak_valid <= 1, both registered.
  - len_cnt decrements each cycle; when it is 0, return to IDLE.
  - Trigger inputs are ignored and hit_cnt stays 0.
- Outside LEAK, leak and leak_valid are registered to 0.
- Changes to key after the ARMED cycle do not affect the burst.

## Timing
- Reset (rst_n=0 at an edge):
  - lfsr=LFSR_SEED, state=IDLE, hit_cnt=0, len_cnt=0, key_snap=0.
  - leak=0, leak_valid=0, active=0.
- Reset asserted mid-burst aborts on that edge. The next cycle shows leak=0 and leak_valid=0.
- Firing sequence, where edge E is the one that counts the final match:
  - State becomes ARMED after E and active=1.
  - The snapshot is taken at E+1.
  - The first leak_valid=1 is visible after E+2.
  - The last leak_valid=1 is visible after E+1+LEAK_LEN.
- leak_valid is high for exactly LEAK_LEN consecutive cycles.
- active is high for LEAK_LEN+1 cycles, and combinationally decodes state.
- Back-to-back operation: a new trigger needs TRIG_HITS fresh matches starting in the first IDLE cycle after the burst.
- A match that arrives in the same cycle as the LEAK→IDLE transition is ignored.
- With TRIG_HITS=1, a single match fires.
- Counter widths: hit_cnt is 8 bits and len_cnt is 16 bits; neither wraps, by the parameter bounds above.

## Structure
- Package trojan_pkg holds:
  - the state enum (IDLE=0, ARMED=1, LEAK=2);
  - a function lfsr_next(value, taps, width).
- Sub-module trojan_lfsr holds the LFSR register, its reset, the zero-reload and the mask replication. It has parameters LFSR_W, LFSR_SEED, LFSR_TAPS and REP, and ports clk, rst_n and mask.
- The top level holds the FSM, hit_cnt, len_cnt, key_snap and the output registers.

## Test plan
- Reset behaviour, with defaults: hold rst_n=0 for 3 cycles, then release. Required response: leak=0 and leak_valid=0, and the LFSR sequence starts DEAD → BD5B. Feeding key=0 with a forced burst shows leak=BD5B_BD5B_BD5B_BD5B pattern alignment checked against the model.
- Trigger counting: send valid A5, A5, then a 1-cycle gap (valid=0), then A5. Required response: fires; the first leak_valid appears 2 cycles after the third match. In a separate run, send A5, A5, 3C, A5. Required response: no fire.
- Burst content: key=0123_4567_89AB_CDEF at the ARMED cycle, then key changed to 0 during the burst. Required response: 32 leak_valid cycles, each leak = 0123456789ABCDEF ^ {4{lfsr}}, and no dependence on the new key.
- Reset mid-burst: assert rst_n=0 at burst cycle 10. Required response: next cycle leak=0, leak_valid=0 and active=0. Three fresh matches are then needed to fire again.
- Parameter variant: KEY_W=32, LFSR_W=8, LFSR_SEED=8'h01, LFSR_TAPS=8'hB8, TRIG_HITS=1, LEAK_LEN=1. Required response: a single match gives exactly 1 leak_valid cycle, and the LFSR period is 255.
- Ignore during burst: matches during LEAK and on the exit cycle do not count. Required response: hit_cnt=0 on the first IDLE cycle.
